// File: rtl/bouton_pkg.sv
// Shared types and timing defaults for the push-button conditioning chain.
// One FSM encoding and one counter-width rule are used by every button channel.
package bouton_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        REPEAT     = 2'd2,
        HOLD_OFF   = 2'd3
    } etat_t;

    // 10 ms debounce, 400 ms before auto-fire, then 100 ms between shots at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int REPEAT_DELAY_DEF    = 40000000;
    localparam int REPEAT_PERIOD_DEF   = 10000000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/anti_rebond.sv
// One button channel: 2-flop synchroniser, counter debounce and press/auto-repeat FSM.
// hold_off parks a held button in HOLD_OFF until it is released and pressed again.
module anti_rebond
    import bouton_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic hold_off,
    output logic stable,
    output logic pulse
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = (cnt_width(REPEAT_DELAY) > cnt_width(REPEAT_PERIOD)) ?
                        cnt_width(REPEAT_DELAY) : cnt_width(REPEAT_PERIOD);
    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic          sync1;
    logic          s;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] nxt_rcnt;
    logic          nxt_pulse;
    etat_t         etat;
    etat_t         nxt_etat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            s      <= 1'b0;
            dcnt   <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= btn;
            s     <= sync1;
            // any agreeing cycle restarts the count, so short glitches never land
            if (s != stable) begin
                if (dcnt == D_LAST) begin
                    stable <= s;
                    dcnt   <= '0;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end else begin
                dcnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            etat  <= IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            etat  <= nxt_etat;
            rcnt  <= nxt_rcnt;
            pulse <= nxt_pulse;
        end
    end

    always_comb begin
        nxt_etat  = etat;
        nxt_rcnt  = rcnt;
        nxt_pulse = 1'b0;
        if (!stable) begin
            nxt_etat = IDLE;
            nxt_rcnt = '0;
        end else if (hold_off) begin
            nxt_etat = HOLD_OFF;
            nxt_rcnt = '0;
        end else begin
            case (etat)
                IDLE: begin
                    nxt_etat  = WAIT_DELAY;
                    nxt_pulse = 1'b1;
                    nxt_rcnt  = '0;
                end
                WAIT_DELAY: begin
                    if (rcnt == RD_LAST) begin
                        nxt_etat  = REPEAT;
                        nxt_pulse = 1'b1;
                        nxt_rcnt  = '0;
                    end else begin
                        nxt_rcnt = rcnt + RW'(1);
                    end
                end
                REPEAT: begin
                    if (rcnt == RP_LAST) begin
                        nxt_pulse = 1'b1;
                        nxt_rcnt  = '0;
                    end else begin
                        nxt_rcnt = rcnt + RW'(1);
                    end
                end
                default: nxt_rcnt = '0;
            endcase
        end
    end

endmodule

// File: rtl/bouton_filtre.sv
// Conditions the left/right buttons into clean one-cycle move pulses for Manette.
// Pressing both at once, or losing the game (enable low), silences both channels.
module bouton_filtre
    import bouton_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic leftButton,
    input  logic rightButton,
    output logic leftPulse,
    output logic rightPulse,
    output logic leftLevel,
    output logic rightLevel
);

    logic left_stable;
    logic right_stable;
    logic left_pulse_r;
    logic right_pulse_r;
    logic hold_off;

    assign hold_off = ~enable | (left_stable & right_stable);

    anti_rebond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_left (
        .clk     (clk),
        .reset   (reset),
        .btn     (leftButton),
        .hold_off(hold_off),
        .stable  (left_stable),
        .pulse   (left_pulse_r)
    );

    anti_rebond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_right (
        .clk     (clk),
        .reset   (reset),
        .btn     (rightButton),
        .hold_off(hold_off),
        .stable  (right_stable),
        .pulse   (right_pulse_r)
    );

    // gate combinationally so a pulse already registered dies the cycle enable drops
    assign leftPulse  = left_pulse_r & enable;
    assign rightPulse = right_pulse_r & enable;
    assign leftLevel  = left_stable;
    assign rightLevel = right_stable;

endmodule

// File: tb/tb_bouton_filtre.sv
// Bench for bouton_filtre: directed scenarios plus random button traffic,
// all checked every cycle against a press-age model of the button rules.
module tb_bouton_filtre;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    typedef logic [31:0] evq_t[$];

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic lb;
    logic rb;
    logic leftPulse;
    logic rightPulse;
    logic leftLevel;
    logic rightLevel;

    bouton_filtre #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .enable     (enable),
        .leftButton (lb),
        .rightButton(rb),
        .leftPulse  (leftPulse),
        .rightPulse (rightPulse),
        .leftLevel  (leftLevel),
        .rightLevel (rightLevel)
    );

    // clock / reset
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] lp_ev[$];
    logic [31:0] rp_ev[$];
    logic [31:0] lv_ev[$];
    logic [31:0] rv_ev[$];
    logic prev_ll = 1'b0;
    logic prev_rl = 1'b0;

    // model: raw-sample history per button, accepted level, press age
    logic hist [2][DB+2];
    logic m_stb [2];
    logic m_pulse [2];
    logic m_active [2];
    logic m_held [2];
    int   m_age [2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < DB + 2; j++) hist[c][j] = 1'b0;
            m_stb[c]    = 1'b0;
            m_pulse[c]  = 1'b0;
            m_active[c] = 1'b0;
            m_held[c]   = 1'b0;
            m_age[c]    = 0;
        end
    endtask

    task automatic model_step();
        logic hold;
        logic raw [2];
        logic flip;
        raw[0] = lb;
        raw[1] = rb;
        hold = !enable || (m_stb[0] && m_stb[1]);
        for (int c = 0; c < 2; c++) begin
            m_pulse[c] = 1'b0;
            if (!m_stb[c]) begin
                m_active[c] = 1'b0;
                m_held[c]   = 1'b0;
            end else if (hold) begin
                m_held[c]   = 1'b1;
                m_active[c] = 1'b0;
            end else if (m_held[c]) begin
                m_active[c] = 1'b0;
            end else if (!m_active[c]) begin
                m_active[c] = 1'b1;
                m_age[c]    = 0;
                m_pulse[c]  = 1'b1;
            end else begin
                m_age[c]   = m_age[c] + 1;
                m_pulse[c] = (m_age[c] == RD) ||
                             (m_age[c] > RD && ((m_age[c] - RD) % RP) == 0);
            end
        end
        for (int c = 0; c < 2; c++) begin
            for (int j = DB + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = raw[c];
            // level accepted once DB synchronised samples in a row disagree with it
            flip = 1'b1;
            for (int j = 2; j < DB + 2; j++) if (hist[c][j] == m_stb[c]) flip = 1'b0;
            if (flip) m_stb[c] = !m_stb[c];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // scoreboard
    task automatic chk(input string name, input logic act, input logic want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, act, want);
        end
    endtask

    task automatic chk_ev(input string name, input evq_t got);
        logic bad;
        bad = (got.size() != exp_q.size());
        if (!bad) foreach (got[i]) if (got[i] != exp_q[i]) bad = 1'b1;
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got %0d events (first %0d) want %0d events (first %0d)",
                     name, got.size(), (got.size() > 0) ? got[0] : 32'd0,
                     exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 32'd0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("leftPulse", leftPulse, m_pulse[0] & enable);
            chk("rightPulse", rightPulse, m_pulse[1] & enable);
            chk("leftLevel", leftLevel, m_stb[0]);
            chk("rightLevel", rightLevel, m_stb[1]);
            if (leftPulse === 1'b1) lp_ev.push_back(cyc);
            if (rightPulse === 1'b1) rp_ev.push_back(cyc);
            if (leftLevel !== prev_ll) lv_ev.push_back(cyc);
            if (rightLevel !== prev_rl) rv_ev.push_back(cyc);
            prev_ll = leftLevel;
            prev_rl = rightLevel;
        end
    end

    // driver tasks
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        lp_ev.delete();
        rp_ev.delete();
        lv_ev.delete();
        rv_ev.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] t0;
        logic [31:0] t1;
        rst_n  = 1'b0;
        enable = 1'b1;
        lb     = 1'b0;
        rb     = 1'b0;
        edges(3);
        chk("reset_leftPulse", leftPulse, 1'b0);
        chk("reset_rightPulse", rightPulse, 1'b0);
        chk("reset_leftLevel", leftLevel, 1'b0);
        chk("reset_rightLevel", rightLevel, 1'b0);
        rst_n = 1'b1;
        edges(5);

        // clean press, held 60 cycles
        clear_ev();
        t0 = cyc;
        lb = 1'b1;
        edges(60);
        lb = 1'b0;
        edges(15);
        exp_q = {t0 + 32'd7, t0 + 32'd27, t0 + 32'd35, t0 + 32'd43, t0 + 32'd51, t0 + 32'd59};
        chk_ev("press_pulses", lp_ev);
        exp_q = {t0 + 32'd6, t0 + 32'd66};
        chk_ev("press_level", lv_ev);

        // bounce on right, then settle high
        clear_ev();
        for (int i = 0; i < 10; i++) begin
            rb = (i % 2 == 0);
            edges(2);
        end
        t0 = cyc;
        rb = 1'b1;
        edges(15);
        exp_q = {t0 + 32'd7};
        chk_ev("bounce_pulse", rp_ev);
        exp_q = {t0 + 32'd6};
        chk_ev("bounce_level", rv_ev);
        rb = 1'b0;
        edges(10);

        // short glitch on left
        clear_ev();
        lb = 1'b1;
        edges(3);
        lb = 1'b0;
        edges(12);
        chk_ev("glitch_level", lv_ev);
        chk_ev("glitch_pulse", lp_ev);

        // conflict: right pressed while left repeats
        clear_ev();
        t0 = cyc;
        lb = 1'b1;
        edges(20);
        rb = 1'b1;
        edges(20);
        rb = 1'b0;
        edges(20);
        exp_q = {t0 + 32'd7};
        chk_ev("conflict_left", lp_ev);
        exp_q.delete();
        chk_ev("conflict_right", rp_ev);
        exp_q = {t0 + 32'd26, t0 + 32'd46};
        chk_ev("conflict_rlevel", rv_ev);
        lb = 1'b0;
        edges(12);
        clear_ev();
        t1 = cyc;
        lb = 1'b1;
        edges(12);
        exp_q = {t1 + 32'd7};
        chk_ev("conflict_repress", lp_ev);
        lb = 1'b0;
        edges(10);

        // enable dropped in the very cycle of the first pulse
        clear_ev();
        t0 = cyc;
        lb = 1'b1;
        edges(7);
        enable = 1'b0;
        edges(20);
        enable = 1'b1;
        edges(30);
        chk_ev("enable_silent", lp_ev);
        lb = 1'b0;
        edges(12);
        clear_ev();
        t1 = cyc;
        lb = 1'b1;
        edges(12);
        exp_q = {t1 + 32'd7};
        chk_ev("enable_repress", lp_ev);
        lb = 1'b0;
        edges(10);

        // reset mid-repeat with the button still held
        t0 = cyc;
        lb = 1'b1;
        edges(40);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_leftPulse", leftPulse, 1'b0);
        chk("async_rightPulse", rightPulse, 1'b0);
        chk("async_leftLevel", leftLevel, 1'b0);
        chk("async_rightLevel", rightLevel, 1'b0);
        edges(3);
        clear_ev();
        t1 = cyc;
        rst_n = 1'b1;
        edges(20);
        exp_q = {t1 + 32'd7};
        chk_ev("reset_repress_pulse", lp_ev);
        exp_q = {t1 + 32'd6};
        chk_ev("reset_repress_level", lv_ev);
        lb = 1'b0;
        edges(12);

        // random traffic
        for (int seg = 0; seg < 150; seg++) begin
            int dur;
            lb     = ($urandom_range(0, 1) == 1);
            rb     = ($urandom_range(0, 3) == 0);
            enable = ($urandom_range(0, 7) != 0);
            dur    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : $urandom_range(10, 60);
            edges(dur);
            if ($urandom_range(0, 29) == 0) begin
                #1;
                rst_n = 1'b0;
                edges(2);
                rst_n = 1'b1;
            end
        end
        enable = 1'b1;
        lb     = 1'b0;
        rb     = 1'b0;
        edges(12);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
